cmac_link_ctrl: RTL and testbench

- Run-time link controller for one CMAC instance.
- Performs the bring-up sequence:
  - enable RX and send LFI/RFI;
  - wait for rx_aligned;
  - debounce it;
  - enable TX and stop sending LFI/RFI.
- Keeps supervising the link afterwards. On alignment timeout it first issues ctl_rx_force_resync pulses; after a set number of failed retries it escalates to an rx_reset pulse. On loss of alignment it drops back to bring-up.
- Sits between the nf_cmac_interface top and the CMAC core control ports, replacing the one-shot startup sequencer.

---
 rtl/cmac_link_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_cmac_link_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmac_link_ctrl.sv
// Run-time link controller for one CMAC: bring-up, alignment supervision and resync/reset recovery.
// Define CMAC_LINK_STATS_EN to build the link_down_cnt statistics counter; otherwise it reads as zero.
module cmac_link_ctrl #(
    parameter int ALIGN_TIMEOUT   = 1000000,
    parameter int DEBOUNCE        = 256,
    parameter int RESYNC_PULSE    = 4,
    parameter int MAX_RETRIES     = 3,
    parameter int RX_RESET_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        rx_aligned,
    input  logic        clr_stats,
    output logic        ctl_rx_enable,
    output logic        ctl_tx_enable,
    output logic        ctl_tx_send_lfi,
    output logic        ctl_tx_send_rfi,
    output logic        ctl_rx_force_resync,
    output logic        rx_reset,
    output logic        link_up,
    output logic [2:0]  state_o,
    output logic [1:0]  retry_cnt,
    output logic [15:0] link_down_cnt
);

    localparam int MAX_AB  = (ALIGN_TIMEOUT > DEBOUNCE) ? ALIGN_TIMEOUT : DEBOUNCE;
    localparam int MAX_CD  = (RESYNC_PULSE > RX_RESET_CYCLES) ? RESYNC_PULSE : RX_RESET_CYCLES;
    localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int TW      = ($clog2(MAX_CNT) > 0) ? $clog2(MAX_CNT) : 1;

    localparam logic [TW-1:0] ALIGN_LAST  = TW'(ALIGN_TIMEOUT - 1);
    localparam logic [TW-1:0] DEB_LAST    = TW'(DEBOUNCE - 1);
    localparam logic [TW-1:0] RESYNC_LAST = TW'(RESYNC_PULSE - 1);
    localparam logic [TW-1:0] RXRST_LAST  = TW'(RX_RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        S_DISABLED   = 3'd0,
        S_WAIT_ALIGN = 3'd1,
        S_DEBOUNCE   = 3'd2,
        S_UP         = 3'd3,
        S_RESYNC     = 3'd4,
        S_RX_RST     = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    retry_q, retry_d;
    logic          link_drop;
    // Control bundle: {rx_en, tx_en, lfi, rfi, resync, rx_reset, link_up}
    logic [6:0]    ctl_q, ctl_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_DISABLED;
            timer_q <= '0;
            retry_q <= '0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            ctl_q   <= ctl_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        retry_d   = retry_q;
        link_drop = 1'b0;
        if (!enable) begin
            state_d = S_DISABLED;
            timer_d = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                S_DISABLED: begin
                    state_d = S_WAIT_ALIGN;
                    timer_d = '0;
                end
                S_WAIT_ALIGN: begin
                    // Alignment seen on the timeout cycle still wins over recovery.
                    if (rx_aligned) begin
                        state_d = S_DEBOUNCE;
                        timer_d = '0;
                    end else if (timer_q == ALIGN_LAST) begin
                        timer_d = '0;
                        if (int'(retry_q) < MAX_RETRIES) begin
                            state_d = S_RESYNC;
                            retry_d = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
                        end else begin
                            state_d = S_RX_RST;
                            retry_d = '0;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                S_DEBOUNCE: begin
                    if (!rx_aligned) begin
                        state_d = S_WAIT_ALIGN;
                        timer_d = '0;
                    end else if (timer_q == DEB_LAST) begin
                        state_d = S_UP;
                        timer_d = '0;
                        retry_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                S_UP: begin
                    if (!rx_aligned) begin
                        state_d   = S_WAIT_ALIGN;
                        timer_d   = '0;
                        link_drop = 1'b1;
                    end
                end
                S_RESYNC: begin
                    if (timer_q == RESYNC_LAST) begin
                        state_d = S_WAIT_ALIGN;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                S_RX_RST: begin
                    if (timer_q == RXRST_LAST) begin
                        state_d = S_WAIT_ALIGN;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: begin
                    state_d = S_DISABLED;
                    timer_d = '0;
                    retry_d = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered copy lines up with state_q.
    always_comb begin
        ctl_d = '0;
        case (state_d)
            S_WAIT_ALIGN: ctl_d = 7'b1011000;
            S_DEBOUNCE:   ctl_d = 7'b1011000;
            S_UP:         ctl_d = 7'b1100001;
            S_RESYNC:     ctl_d = 7'b1011100;
            S_RX_RST:     ctl_d = 7'b1011010;
            default:      ctl_d = '0;
        endcase
    end

    assign ctl_rx_enable       = ctl_q[6];
    assign ctl_tx_enable       = ctl_q[5];
    assign ctl_tx_send_lfi     = ctl_q[4];
    assign ctl_tx_send_rfi     = ctl_q[3];
    assign ctl_rx_force_resync = ctl_q[2];
    assign rx_reset            = ctl_q[1];
    assign link_up             = ctl_q[0];
    assign state_o             = state_q;
    assign retry_cnt           = retry_q;

`ifdef CMAC_LINK_STATS_EN
    logic [15:0] ldc_q;

    // A clear on the same cycle as a link drop leaves the counter at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ldc_q <= '0;
        end else if (clr_stats) begin
            ldc_q <= '0;
        end else if (link_drop && (ldc_q != 16'hFFFF)) begin
            ldc_q <= ldc_q + 16'd1;
        end
    end

    assign link_down_cnt = ldc_q;
`else
    logic unused_stats;

    assign unused_stats  = clr_stats ^ link_drop;
    assign link_down_cnt = '0;
`endif

endmodule

// File: tb/tb_cmac_link_ctrl.sv
// Self-checking bench for cmac_link_ctrl: phase table with end-of-phase expectations plus a
// per-cycle reference model feeding an expected-output queue.
module tb_cmac_link_ctrl;

    localparam int AT  = 100;
    localparam int DB  = 8;
    localparam int RP  = 4;
    localparam int MR  = 2;
    localparam int RRC = 16;

    localparam logic [2:0] ST_DIS = 3'd0;
    localparam logic [2:0] ST_WA  = 3'd1;
    localparam logic [2:0] ST_DB  = 3'd2;
    localparam logic [2:0] ST_UP  = 3'd3;
    localparam logic [2:0] ST_RS  = 3'd4;
    localparam logic [2:0] ST_RR  = 3'd5;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        rx_aligned;
    logic        clr_stats;
    logic        ctl_rx_enable;
    logic        ctl_tx_enable;
    logic        ctl_tx_send_lfi;
    logic        ctl_tx_send_rfi;
    logic        ctl_rx_force_resync;
    logic        rx_reset;
    logic        link_up;
    logic [2:0]  state_o;
    logic [1:0]  retry_cnt;
    logic [15:0] link_down_cnt;

    int checks;
    int errors;

    cmac_link_ctrl #(
        .ALIGN_TIMEOUT  (AT),
        .DEBOUNCE       (DB),
        .RESYNC_PULSE   (RP),
        .MAX_RETRIES    (MR),
        .RX_RESET_CYCLES(RRC)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .enable             (enable),
        .rx_aligned         (rx_aligned),
        .clr_stats          (clr_stats),
        .ctl_rx_enable      (ctl_rx_enable),
        .ctl_tx_enable      (ctl_tx_enable),
        .ctl_tx_send_lfi    (ctl_tx_send_lfi),
        .ctl_tx_send_rfi    (ctl_tx_send_rfi),
        .ctl_rx_force_resync(ctl_rx_force_resync),
        .rx_reset           (rx_reset),
        .link_up            (link_up),
        .state_o            (state_o),
        .retry_cnt          (retry_cnt),
        .link_down_cnt      (link_down_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          en;
        bit          al;
        bit          clr;
        int          cycles;
        logic [2:0]  st;
        logic [1:0]  rt;
        logic [15:0] ldc;
        string       name;
    } vec_t;

    vec_t        vecs[$];
    logic [27:0] expQ[$];

    int mState;
    int mTimer;
    int mRetry;
    int mLdc;

    // Expected link-down count depends on whether the statistics counter is built.
    function automatic logic [15:0] ldcExp(input int v);
`ifdef CMAC_LINK_STATS_EN
        return 16'(v);
`else
        if (v < 0) return 16'hFFFF;
        return 16'd0;
`endif
    endfunction

    // Control bits per state: {rx_en, tx_en, lfi, rfi, resync, rx_reset, link_up}.
    function automatic logic [6:0] stateOuts(input int s);
        case (s)
            1, 2:    return 7'b1011000;
            3:       return 7'b1100001;
            4:       return 7'b1011100;
            5:       return 7'b1011010;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [27:0] actualVec();
        return {state_o, ctl_rx_enable, ctl_tx_enable, ctl_tx_send_lfi, ctl_tx_send_rfi,
                ctl_rx_force_resync, rx_reset, link_up, retry_cnt, link_down_cnt};
    endfunction

    task automatic modelStep(input bit en, input bit al, input bit clr);
        int nS = mState;
        int nT = mTimer;
        int nR = mRetry;
        bit drop = 1'b0;
        if (!en) begin
            nS = 0; nT = 0; nR = 0;
        end else begin
            case (mState)
                0: begin nS = 1; nT = 0; end
                1: begin
                    if (al) begin
                        nS = 2; nT = 0;
                    end else if (mTimer == AT - 1) begin
                        nT = 0;
                        if (mRetry < MR) begin
                            nS = 4; nR = (mRetry >= 3) ? 3 : mRetry + 1;
                        end else begin
                            nS = 5; nR = 0;
                        end
                    end else begin
                        nT = mTimer + 1;
                    end
                end
                2: begin
                    if (!al) begin
                        nS = 1; nT = 0;
                    end else if (mTimer == DB - 1) begin
                        nS = 3; nT = 0; nR = 0;
                    end else begin
                        nT = mTimer + 1;
                    end
                end
                3: if (!al) begin nS = 1; nT = 0; drop = 1'b1; end
                4: begin
                    if (mTimer == RP - 1) begin nS = 1; nT = 0; end
                    else nT = mTimer + 1;
                end
                5: begin
                    if (mTimer == RRC - 1) begin nS = 1; nT = 0; end
                    else nT = mTimer + 1;
                end
                default: begin nS = 0; nT = 0; nR = 0; end
            endcase
        end
`ifdef CMAC_LINK_STATS_EN
        if (clr) mLdc = 0;
        else if (drop && mLdc < 65535) mLdc = mLdc + 1;
`else
        if (clr && drop) mLdc = 0;
`endif
        mState = nS;
        mTimer = nT;
        mRetry = nR;
    endtask

    task automatic applyStimulus(input bit en, input bit al, input bit clr);
        enable     = en;
        rx_aligned = al;
        clr_stats  = clr;
        modelStep(en, al, clr);
        expQ.push_back({3'(mState), stateOuts(mState), 2'(mRetry), 16'(mLdc)});
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name);
        logic [27:0] exp;
        logic [27:0] act;
        checks++;
        act = actualVec();
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: scoreboard empty, got %h", name, act);
        end else begin
            exp = expQ.pop_front();
            if (act !== exp) begin
                errors++;
                $display("[TB] FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
            end
        end
    endtask

    task automatic addVec(input bit en, input bit al, input bit clr, input int cycles,
                          input logic [2:0] st, input logic [1:0] rt, input logic [15:0] ldc,
                          input string name);
        vec_t v;
        v.en = en; v.al = al; v.clr = clr; v.cycles = cycles;
        v.st = st; v.rt = rt; v.ldc = ldc; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic runPhase(input vec_t v);
        for (int c = 0; c < v.cycles; c++) begin
            applyStimulus(v.en, v.al, v.clr);
            checkOutput(v.name);
        end
        checks++;
        if ({state_o, retry_cnt, link_down_cnt} !== {v.st, v.rt, v.ldc}) begin
            errors++;
            $display("[TB] FAIL %s end: got st=%0d rt=%0d ldc=%0d expected st=%0d rt=%0d ldc=%0d",
                     v.name, state_o, retry_cnt, link_down_cnt, v.st, v.rt, v.ldc);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        mState     = 0;
        mTimer     = 0;
        mRetry     = 0;
        mLdc       = 0;
        rst_n      = 1'b0;
        enable     = 1'b0;
        rx_aligned = 1'b0;
        clr_stats  = 1'b0;

        // Nominal bring-up
        addVec(1, 0, 0, 10, ST_WA, 0, ldcExp(0), "nom_wait");
        addVec(1, 1, 0, 1,  ST_DB, 0, ldcExp(0), "nom_deb_entry");
        addVec(1, 1, 0, 7,  ST_DB, 0, ldcExp(0), "nom_deb_hold");
        addVec(1, 1, 0, 1,  ST_UP, 0, ldcExp(0), "nom_up");
        // Link flaps and statistics clear
        addVec(1, 0, 0, 1,  ST_WA, 0, ldcExp(1), "flap1_drop");
        addVec(1, 1, 0, 9,  ST_UP, 0, ldcExp(1), "flap1_up");
        addVec(1, 0, 0, 1,  ST_WA, 0, ldcExp(2), "flap2_drop");
        addVec(1, 1, 0, 9,  ST_UP, 0, ldcExp(2), "flap2_up");
        addVec(1, 0, 0, 1,  ST_WA, 0, ldcExp(3), "flap3_drop");
        addVec(1, 1, 0, 9,  ST_UP, 0, ldcExp(3), "flap3_up");
        addVec(1, 1, 1, 1,  ST_UP, 0, ldcExp(0), "clr_stats");
        addVec(1, 0, 0, 1,  ST_WA, 0, ldcExp(1), "flap4_drop");
        addVec(1, 1, 0, 9,  ST_UP, 0, ldcExp(1), "flap4_up");
        addVec(1, 0, 1, 1,  ST_WA, 0, ldcExp(0), "clr_vs_inc");
        // Debounce glitch
        addVec(1, 1, 0, 5,  ST_DB, 0, ldcExp(0), "glitch_high5");
        addVec(1, 0, 0, 1,  ST_WA, 0, ldcExp(0), "glitch_low");
        addVec(1, 1, 0, 8,  ST_DB, 0, ldcExp(0), "glitch_rerun");
        addVec(1, 1, 0, 1,  ST_UP, 0, ldcExp(0), "glitch_up");
        // Timeout escalation
        addVec(1, 0, 0, 1,  ST_WA, 0, ldcExp(1), "to_drop");
        addVec(1, 0, 0, 99, ST_WA, 0, ldcExp(1), "to_wait1");
        addVec(1, 0, 0, 1,  ST_RS, 1, ldcExp(1), "to_resync1");
        addVec(1, 0, 0, 3,  ST_RS, 1, ldcExp(1), "to_resync1_hold");
        addVec(1, 0, 0, 1,  ST_WA, 1, ldcExp(1), "to_resync1_end");
        addVec(1, 0, 0, 99, ST_WA, 1, ldcExp(1), "to_wait2");
        addVec(1, 0, 0, 1,  ST_RS, 2, ldcExp(1), "to_resync2");
        addVec(1, 1, 0, 3,  ST_RS, 2, ldcExp(1), "to_resync2_ign");
        addVec(1, 0, 0, 1,  ST_WA, 2, ldcExp(1), "to_resync2_end");
        addVec(1, 0, 0, 99, ST_WA, 2, ldcExp(1), "to_wait3");
        addVec(1, 0, 0, 1,  ST_RR, 0, ldcExp(1), "to_rxrst");
        addVec(1, 1, 0, 15, ST_RR, 0, ldcExp(1), "to_rxrst_ign");
        addVec(1, 0, 0, 1,  ST_WA, 0, ldcExp(1), "to_rxrst_end");
        addVec(1, 0, 0, 99, ST_WA, 0, ldcExp(1), "rep_wait1");
        addVec(1, 0, 0, 1,  ST_RS, 1, ldcExp(1), "rep_resync1");
        addVec(1, 0, 0, 3,  ST_RS, 1, ldcExp(1), "rep_resync1_hold");
        addVec(1, 0, 0, 1,  ST_WA, 1, ldcExp(1), "rep_resync1_end");
        // Alignment on the timeout cycle wins; debounce drop keeps retry_cnt
        addVec(1, 0, 0, 99, ST_WA, 1, ldcExp(1), "prio_wait");
        addVec(1, 1, 0, 1,  ST_DB, 1, ldcExp(1), "prio_align");
        addVec(1, 0, 0, 1,  ST_WA, 1, ldcExp(1), "prio_deb_drop");
        addVec(1, 0, 0, 99, ST_WA, 1, ldcExp(1), "rec_wait1");
        addVec(1, 0, 0, 1,  ST_RS, 2, ldcExp(1), "rec_resync2");
        addVec(1, 0, 0, 3,  ST_RS, 2, ldcExp(1), "rec_resync2_hold");
        addVec(1, 0, 0, 1,  ST_WA, 2, ldcExp(1), "rec_resync2_end");
        addVec(1, 0, 0, 99, ST_WA, 2, ldcExp(1), "rec_wait2");
        addVec(1, 0, 0, 1,  ST_RR, 0, ldcExp(1), "rec_rxrst");
        addVec(1, 0, 0, 1,  ST_RR, 0, ldcExp(1), "rec_rxrst_c2");
        // Disable mid-recovery
        addVec(0, 0, 0, 1,  ST_DIS, 0, ldcExp(1), "disable");
        addVec(0, 1, 0, 2,  ST_DIS, 0, ldcExp(1), "disable_hold");
        // Re-enable back to UP
        addVec(1, 1, 0, 1,  ST_WA, 0, ldcExp(1), "reup_wait");
        addVec(1, 1, 0, 8,  ST_DB, 0, ldcExp(1), "reup_deb");
        addVec(1, 1, 0, 1,  ST_UP, 0, ldcExp(1), "reup_up");

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (actualVec() !== 28'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h expected %h", actualVec(), 28'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            runPhase(vecs[i]);
        end

        // Asynchronous reset asserted between edges while UP
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (actualVec() !== 28'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h expected %h", actualVec(), 28'd0);
        end
        mState = 0; mTimer = 0; mRetry = 0; mLdc = 0;
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 1, 0);
        checkOutput("post_reset_disabled");
        applyStimulus(1, 0, 0);
        checkOutput("post_reset_enable");

        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
